// File: rtl/nx_fifo_rd_stage.sv
// Two-entry read stage draining a zero-latency FIFO into a valid/ready port.
// Optional backpressure counter: define NX_FIFO_RD_STALL_CNT_EN.
module nx_fifo_rd_stage #(
  parameter int WIDTH   = 106,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_rdata,
  output logic               fifo_ren,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;

  logic push;
  logic pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Pop decision never looks at out_ready, only at occupancy.
  always_comb begin
    fifo_ren  = !fifo_empty && (state_q != TWO)
              && !flush && !rst;
    out_valid = (state_q != EMPTY);
    out_data  = slot0_q;
    push      = fifo_ren;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) state_d = ONE;
        end
        ONE: begin
          if (push && !pop)      state_d = TWO;
          else if (!push && pop) state_d = EMPTY;
          else                   state_d = ONE;
        end
        TWO: begin
          if (pop) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Empty slots are kept at zero so they never leak stale data.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      slot0_d = '0;
      slot1_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) slot0_d = fifo_rdata;
        end
        ONE: begin
          if (push && pop) begin
            slot0_d = fifo_rdata;
          end else if (push) begin
            slot1_d = fifo_rdata;
          end else if (pop) begin
            slot0_d = '0;
          end
        end
        TWO: begin
          if (pop) begin
            slot0_d = slot1_q;
            slot1_d = '0;
          end
        end
        default: begin
          slot0_d = '0;
          slot1_d = '0;
        end
      endcase
    end
  end

`ifdef NX_FIFO_RD_STALL_CNT_EN
  localparam logic [STALL_W-1:0] STALL_ONE =
    {{(STALL_W-1){1'b0}}, 1'b1};

  logic [STALL_W-1:0] stall_q, stall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid && !out_ready
                 && (stall_q != '1)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
